// File: rtl/uart_event_rx.sv
// 8N1 UART receiver plus ASCII line parser turning "IIII,S*16,E*16,D*16\n" hex lines into events.
// Define LOWERCASE_HEX_EN to also accept 'a'-'f' as hex digits.
module uart_event_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_id,
    output logic [63:0] evt_start_ts,
    output logic [63:0] evt_end_ts,
    output logic [63:0] evt_delta,
    output logic        err_pulse
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int HALF_BIT   = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES + 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
    typedef enum logic [3:0] {P_ID, P_C1, P_S, P_C2, P_E, P_C3, P_D, P_NL, P_RESYNC} p_state_t;

    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
`ifdef LOWERCASE_HEX_EN
        else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
`endif
        return r;
    endfunction

    // Both synchronizer flops reset to the idle level so reset never fakes a start bit.
    logic rx_m, rx_s;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_state_t      rx_state, rx_state_nx;
    logic [CW-1:0]  bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     rx_shift;
    logic           tick, half_tick, byte_stb, frame_err;

    assign tick      = (bit_cnt == CW'(BIT_CYCLES - 1));
    assign half_tick = (bit_cnt == CW'(HALF_BIT - 1));

    always_comb begin
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        rx_state_nx = rx_state;
        byte_stb    = 1'b0;
        frame_err   = 1'b0;
        case (rx_state)
            R_IDLE:  if (!rx_s) rx_state_nx = R_START;
            R_START: if (half_tick) rx_state_nx = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_idx == 3'd7) rx_state_nx = R_STOP;
            R_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        byte_stb    = 1'b1;
                        rx_state_nx = R_IDLE;
                    end else begin
                        frame_err   = 1'b1;
                        rx_state_nx = R_BREAK;
                    end
                end
            end
            R_BREAK: if (rx_s) rx_state_nx = R_IDLE;
            default: rx_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nx;
            // The bit timer restarts on every state change and every full bit period.
            if (rx_state != rx_state_nx || tick) bit_cnt <= '0;
            else                                 bit_cnt <= bit_cnt + 1'b1;
            if (rx_state == R_START) bit_idx <= '0;
            if (rx_state == R_DATA && tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    p_state_t    p_state, p_nx, field_nx, comma_nx;
    logic [63:0] acc, acc_sh;
    logic [3:0]  dig_cnt, last_dig;
    logic [15:0] id_w;
    logic [63:0] s_w, e_w;
    logic [4:0]  hv;
    logic        is_nl, is_comma;
    logic        syn_err, ovr_err, dig_shift, field_done, acc_clr, load_evt;

    assign hv       = hex_val(rx_shift);
    assign is_nl    = (rx_shift == 8'h0A);
    assign is_comma = (rx_shift == 8'h2C);
    assign acc_sh   = {acc[59:0], hv[3:0]};

    always_comb begin
        last_dig = (p_state == P_ID) ? 4'd3 : 4'd15;
        field_nx = P_NL;
        comma_nx = P_D;
        case (p_state)
            P_ID:    field_nx = P_C1;
            P_S:     field_nx = P_C2;
            P_E:     field_nx = P_C3;
            P_C1:    comma_nx = P_S;
            P_C2:    comma_nx = P_E;
            default: ;
        endcase
    end

    always_comb begin
        p_nx       = p_state;
        syn_err    = 1'b0;
        ovr_err    = 1'b0;
        dig_shift  = 1'b0;
        field_done = 1'b0;
        acc_clr    = 1'b0;
        load_evt   = 1'b0;
        if (frame_err) begin
            p_nx = P_RESYNC;
        end else if (byte_stb) begin
            case (p_state)
                P_ID, P_S, P_E, P_D: begin
                    if (hv[4]) begin
                        dig_shift = 1'b1;
                        if (dig_cnt == last_dig) begin
                            field_done = 1'b1;
                            p_nx       = field_nx;
                        end
                    end else if (is_nl) begin
                        syn_err = 1'b1;
                        acc_clr = 1'b1;
                        p_nx    = P_ID;
                    end else begin
                        syn_err = 1'b1;
                        p_nx    = P_RESYNC;
                    end
                end
                P_C1, P_C2, P_C3: begin
                    if (is_comma) begin
                        acc_clr = 1'b1;
                        p_nx    = comma_nx;
                    end else if (is_nl) begin
                        syn_err = 1'b1;
                        acc_clr = 1'b1;
                        p_nx    = P_ID;
                    end else begin
                        syn_err = 1'b1;
                        p_nx    = P_RESYNC;
                    end
                end
                P_NL: begin
                    if (is_nl) begin
                        acc_clr = 1'b1;
                        p_nx    = P_ID;
                        if (evt_valid && !evt_ready) ovr_err  = 1'b1;
                        else                         load_evt = 1'b1;
                    end else begin
                        syn_err = 1'b1;
                        p_nx    = P_RESYNC;
                    end
                end
                P_RESYNC: begin
                    if (is_nl) begin
                        acc_clr = 1'b1;
                        p_nx    = P_ID;
                    end
                end
                default: p_nx = P_RESYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state      <= P_ID;
            acc          <= '0;
            dig_cnt      <= '0;
            id_w         <= '0;
            s_w          <= '0;
            e_w          <= '0;
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            evt_start_ts <= '0;
            evt_end_ts   <= '0;
            evt_delta    <= '0;
            err_pulse    <= 1'b0;
        end else begin
            p_state <= p_nx;
            if (acc_clr) begin
                acc     <= '0;
                dig_cnt <= '0;
            end else if (dig_shift) begin
                acc     <= acc_sh;
                dig_cnt <= dig_cnt + 1'b1;
            end
            if (field_done && p_state == P_ID) id_w <= acc_sh[15:0];
            if (field_done && p_state == P_S)  s_w  <= acc_sh;
            if (field_done && p_state == P_E)  e_w  <= acc_sh;
            // The delta field is still in acc when the newline arrives.
            if (load_evt) begin
                evt_valid    <= 1'b1;
                evt_id       <= id_w;
                evt_start_ts <= s_w;
                evt_end_ts   <= e_w;
                evt_delta    <= acc;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            err_pulse <= frame_err | syn_err | ovr_err;
        end
    end

endmodule
